prirv32_imem_resp: RTL and testbench
====================================

// Module: priRV32_imem_resp
// PURPOSE
//  Instruction-memory responder for the priRV32 fetch path: the far end of the IFU fetch interface.
//  Accepts word-fetch requests, returns the instruction word after a fixed number of wait states.
//  Flags misaligned and out-of-range fetches.
//  A loader write port fills the word array after power-on reset, before the core starts fetching.
// PARAMETERS
//  DEPTH        1024          number of 32-bit words in the array (power of two)
//  WAIT_CYCLES  1             extra wait states between accept and response (0..15)
//  BASE_ADDR    32'h0000_0000 byte address of word 0
// PORTS
//  clk_in      in   1   core clock; the only clock
//  rst_in      in   1   synchronous, active-high reset
//  req_i       in   1   fetch request valid
//  addr_i      in   32  fetch byte address; sampled when req_i && gnt_o
//  gnt_o       out  1   responder can accept a request this cycle
//  rvalid_o    out  1   response valid, one-cycle pulse
//  rdata_o     out  32  instruction word; valid while rvalid_o
//  err_o       out  1   fetch fault; valid while rvalid_o
//  busy_o      out  1   a request is in flight (WAIT or RESP)
//  ld_we_i     in   1   loader write enable
//  ld_addr_i   in   log2(DEPTH)  loader word index
//  ld_wdata_i  in   32  loader write data
//  fetch_cnt_o out  32  count of completed responses
// BEHAVIOUR
//  Reset (rst_in sampled high at a clk_in edge):
//   - state=IDLE; rvalid_o=0, rdata_o=0, err_o=0, busy_o=0, fetch_cnt_o=0.
//   - gnt_o=0 while rst_in is high; any in-flight request is dropped with no response.
//   - array contents are NOT cleared.
//  FSM IDLE/WAIT/RESP:
//   - gnt_o = !rst_in && !ld_we_i && (state==IDLE || state==RESP).
//   - Accept on edge E (req_i && gnt_o): latch addr_i, compute fault, read array word synchronously.
//   - Next state is WAIT with wait_cnt=WAIT_CYCLES-1 if WAIT_CYCLES>0, else RESP.
//   - WAIT: decrement wait_cnt each cycle; go to RESP when it reaches 0.
//   - RESP lasts exactly one cycle with rvalid_o=1 and fetch_cnt_o+1 (wraps at 2^32).
//   - Leaving RESP: goes to WAIT/RESP if a new request is accepted in the same cycle, else IDLE.
//  Latency: request accepted at edge E gives rvalid_o high in cycle E+1+WAIT_CYCLES.
//   Back-to-back throughput is one fetch per WAIT_CYCLES+1 cycles.
//  Faults (err_o=1, rdata_o=0):
//   - addr_i[1:0]!=0, or
//   - (addr_i-BASE_ADDR) >= DEPTH*4, using unsigned 32-bit subtraction; addresses below BASE wrap and therefore fault.
//   - Faulting fetches still take full latency and still increment fetch_cnt_o.
//  Data path:
//   - word index = (addr_i-BASE_ADDR)[log2(DEPTH)+1:2].
//   - Data is captured at the accept edge; later loader writes do not alter an in-flight response.
//  Loader:
//   - ld_we_i writes ld_wdata_i to word ld_addr_i on the edge, in any state; it is ignored while rst_in is high.
//   - A load and an accept never share an edge, because ld_we_i forces gnt_o=0.
//  rvalid_o, rdata_o, err_o are registered; rdata_o holds its last value when rvalid_o=0.
// TESTING
//  T1: load word 0=32'h0000_0093, WAIT_CYCLES=1, req at 0x0 accepted at edge E -> rvalid_o=1 in cycle E+2, rdata_o=32'h0000_0093, err_o=0, fetch_cnt_o=1.
//  T2: req held high with addresses 0x0,0x4,0x8 (words loaded 1,2,3) -> three responses 1,2,3, spaced 2 cycles apart, gnt_o high in each RESP cycle.
//  T3: req at 0x2, then at BASE+DEPTH*4 -> two responses, each with err_o=1 and rdata_o=0; fetch_cnt_o increments by 2.
//  T4: ld_we_i high with req_i high in IDLE -> gnt_o=0, no accept; the written word reads back on the next fetch.
//  T5: rst_in asserted during WAIT -> no rvalid_o pulse, busy_o=0 next cycle, fetch_cnt_o=0, array data preserved on a re-fetch.
//  T6: WAIT_CYCLES=0 build, continuous requests -> one rvalid_o per cycle after the first, with correct data each cycle.

Source files
------------

// File: rtl/prirv32_imem_resp_if.sv
// Fetch-side bus between the priRV32 IFU (master) and the instruction
// memory responder (slave).
//   req    : fetch request valid            (master -> slave)
//   addr   : fetch byte address             (master -> slave)
//   gnt    : responder can accept this cycle (slave -> master)
//   rvalid : one-cycle response pulse       (slave -> master)
//   rdata  : instruction word, valid with rvalid
//   err    : fetch fault, valid with rvalid
interface prirv32_imem_resp_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, addr,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/prirv32_imem_resp.sv
// Instruction-memory responder at the far end of the priRV32 fetch path.
// Accepts word fetches, answers after WAIT_CYCLES wait states, flags
// misaligned / out-of-range fetches, and exposes a loader write port used to
// fill the word array before the core starts running.
// Ports:
//   clk_in       core clock (only clock)
//   rst_in       synchronous active-high reset
//   bus          fetch bus (slave side): req/addr in, gnt/rvalid/rdata/err out
//   busy_o       a request is in flight (WAIT or RESP)
//   ld_we_i      loader write enable
//   ld_addr_i    loader word index
//   ld_wdata_i   loader write data
//   fetch_cnt_o  number of completed responses (wraps at 2^32)
module prirv32_imem_resp #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  prirv32_imem_resp_if.slave       bus,
  output logic                     busy_o,
  input  logic                     ld_we_i,
  input  logic [$clog2(DEPTH)-1:0] ld_addr_i,
  input  logic [31:0]              ld_wdata_i,
  output logic [31:0]              fetch_cnt_o
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0]  WAIT_INIT = ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);
  // One past the last valid byte offset; 33 bits so DEPTH*4 cannot overflow.
  localparam logic [32:0] LIMIT     = 33'(DEPTH) * 33'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        enter_resp;
  logic        rvalid_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [31:0] cnt_q;
  logic        resp_err;

  logic          gnt;
  logic          accept;
  logic [31:0]   offset;
  logic          fault;
  logic [AW-1:0] rd_idx;

  logic [31:0] mem [DEPTH];

  // The loader owns the array on any edge it writes, so it also blocks grants.
  assign gnt    = !rst_in && !ld_we_i && (state_q == ST_IDLE || state_q == ST_RESP);
  assign accept = bus.req && gnt;

  // Unsigned subtraction: addresses below BASE_ADDR wrap to huge offsets and
  // land in the out-of-range fault.
  assign offset = bus.addr - BASE_ADDR;
  assign fault  = (bus.addr[1:0] != 2'b00) || ({1'b0, offset} >= LIMIT);
  assign rd_idx = offset[AW+1:2];

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    enter_resp = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_RESP: begin
        // RESP is a single cycle; it chains into a new fetch only if one is
        // accepted right now.
        state_d = ST_IDLE;
        if (accept) begin
          if (ZERO_WAIT) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d    = ST_WAIT;
            wait_cnt_d = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 4'd0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      rvalid_q   <= enter_resp;
      if (enter_resp) begin
        err_q <= resp_err;
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  // Loader write port; the array itself is never reset.
  always_ff @(posedge clk_in) begin
    if (ld_we_i && !rst_in) begin
      mem[ld_addr_i] <= ld_wdata_i;
    end
  end

  generate
    if (WAIT_CYCLES == 0) begin : g_zero_wait
      // Accept edge is also the RESP-entry edge: read straight into the
      // output register.
      always_ff @(posedge clk_in) begin
        if (rst_in) begin
          rdata_q <= 32'd0;
        end else if (accept) begin
          rdata_q <= fault ? 32'd0 : mem[rd_idx];
        end
      end
      assign resp_err = fault;
    end else begin : g_wait
      // Word and fault are frozen at accept, so loader writes during WAIT
      // cannot leak into this response; the output register only updates on
      // RESP entry and otherwise holds its last value.
      logic [31:0] word_q;
      logic        fault_q;

      always_ff @(posedge clk_in) begin
        if (accept) begin
          word_q  <= mem[rd_idx];
          fault_q <= fault;
        end
      end

      always_ff @(posedge clk_in) begin
        if (rst_in) begin
          rdata_q <= 32'd0;
        end else if (enter_resp) begin
          rdata_q <= fault_q ? 32'd0 : word_q;
        end
      end
      assign resp_err = fault_q;
    end
  endgenerate

  assign bus.gnt     = gnt;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign bus.err     = err_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign fetch_cnt_o = cnt_q;

endmodule

// File: tb/tb_prirv32_imem_resp.sv
// Bench for prirv32_imem_resp: two instances (one wait state at base 0, zero
// wait states at a non-zero base) checked every cycle against a latency /
// scoreboard model built from the fetch rules.
module tb_prirv32_imem_resp;

  localparam int          DEPTH  = 64;
  localparam logic [31:0] BASE_B = 32'h0000_0200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst_v;
  logic [1:0]       req_v;
  logic [1:0][31:0] addr_v;
  logic [1:0]       ld_we_v;
  logic [1:0][5:0]  ld_addr_v;
  logic [1:0][31:0] ld_wdata_v;

  logic [1:0]       gnt_w, rvalid_w, err_w, busy_w;
  logic [1:0][31:0] rdata_w, cnt_w;

  prirv32_imem_resp_if bus_a ();
  prirv32_imem_resp_if bus_b ();

  assign bus_a.req   = req_v[0];
  assign bus_a.addr  = addr_v[0];
  assign bus_b.req   = req_v[1];
  assign bus_b.addr  = addr_v[1];
  assign gnt_w[0]    = bus_a.gnt;
  assign gnt_w[1]    = bus_b.gnt;
  assign rvalid_w[0] = bus_a.rvalid;
  assign rvalid_w[1] = bus_b.rvalid;
  assign rdata_w[0]  = bus_a.rdata;
  assign rdata_w[1]  = bus_b.rdata;
  assign err_w[0]    = bus_a.err;
  assign err_w[1]    = bus_b.err;

  prirv32_imem_resp #(.DEPTH(DEPTH), .WAIT_CYCLES(1), .BASE_ADDR(32'h0)) dut_a (
    .clk_in(clk), .rst_in(rst_v[0]), .bus(bus_a.slave), .busy_o(busy_w[0]),
    .ld_we_i(ld_we_v[0]), .ld_addr_i(ld_addr_v[0]), .ld_wdata_i(ld_wdata_v[0]),
    .fetch_cnt_o(cnt_w[0])
  );

  prirv32_imem_resp #(.DEPTH(DEPTH), .WAIT_CYCLES(0), .BASE_ADDR(BASE_B)) dut_b (
    .clk_in(clk), .rst_in(rst_v[1]), .bus(bus_b.slave), .busy_o(busy_w[1]),
    .ld_we_i(ld_we_v[1]), .ld_addr_i(ld_addr_v[1]), .ld_wdata_i(ld_wdata_v[1]),
    .fetch_cnt_o(cnt_w[1])
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          edge_cnt = 0;
  bit          mon_en = 1'b0;
  logic [31:0] mm [2][DEPTH];
  bit          pend_valid [2];
  int          pend_due   [2];
  logic [31:0] pend_data  [2];
  bit          pend_err   [2];
  logic [31:0] cnt_m      [2];
  logic [31:0] last_rdata [2];
  bit          last_err   [2];

  function automatic int wait_of(input int k);
    return (k == 0) ? 1 : 0;
  endfunction

  function automatic logic [31:0] base_of(input int k);
    return (k == 0) ? 32'h0 : BASE_B;
  endfunction

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Called once per cycle at the falling edge: first judges the outputs of the
  // cycle that follows rising edge edge_cnt, then predicts what the next rising
  // edge does with the inputs currently applied.
  task automatic model_step(input int k);
    bit          due_now, in_wait, gnt_exp, f;
    logic [31:0] a, off;
    due_now = pend_valid[k] && (pend_due[k] == edge_cnt);
    in_wait = pend_valid[k] && (pend_due[k] > edge_cnt);
    gnt_exp = !rst_v[k] && !ld_we_v[k] && !in_wait;
    if (due_now) begin
      cnt_m[k]      = cnt_m[k] + 32'd1;
      last_rdata[k] = pend_data[k];
      last_err[k]   = pend_err[k];
      pend_valid[k] = 1'b0;
      $display("dut%0d resp t=%0d data=%h err=%0d cnt=%0d", k, edge_cnt,
               rdata_w[k], err_w[k], cnt_w[k]);
    end
    check($sformatf("dut%0d rvalid", k), 32'(rvalid_w[k]), 32'(due_now));
    check($sformatf("dut%0d rdata", k), rdata_w[k], last_rdata[k]);
    check($sformatf("dut%0d err", k), 32'(err_w[k]), 32'(last_err[k]));
    check($sformatf("dut%0d fetch_cnt", k), cnt_w[k], cnt_m[k]);
    check($sformatf("dut%0d busy", k), 32'(busy_w[k]), 32'(due_now || in_wait));
    check($sformatf("dut%0d gnt", k), 32'(gnt_w[k]), 32'(gnt_exp));

    if (rst_v[k]) begin
      pend_valid[k] = 1'b0;
      cnt_m[k]      = 32'd0;
      last_rdata[k] = 32'd0;
      last_err[k]   = 1'b0;
    end else begin
      if (ld_we_v[k]) mm[k][ld_addr_v[k]] = ld_wdata_v[k];
      if (req_v[k] && gnt_exp) begin
        a   = addr_v[k];
        off = a - base_of(k);
        f   = (a[1:0] != 2'b00) || ({32'd0, off} >= 64'(DEPTH * 4));
        pend_valid[k] = 1'b1;
        pend_due[k]   = edge_cnt + 1 + wait_of(k);
        pend_err[k]   = f;
        pend_data[k]  = f ? 32'd0 : mm[k][off[7:2]];
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      model_step(0);
      model_step(1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input int k, input bit r, input bit rq, input logic [31:0] a,
                       input bit we, input logic [5:0] la, input logic [31:0] wd);
    @(posedge clk);
    #1;
    rst_v[k]      = r;
    req_v[k]      = rq;
    addr_v[k]     = a;
    ld_we_v[k]    = we;
    ld_addr_v[k]  = la;
    ld_wdata_v[k] = wd;
  endtask

  task automatic idle(input int k, input int n);
    for (int i = 0; i < n; i++) drive(k, 1'b0, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0);
  endtask

  // Presents a request and returns at the falling edge just before the edge
  // that accepts it; request stays high for the caller to change next.
  task automatic fetch(input int k, input logic [31:0] a);
    bit granted;
    granted = 1'b0;
    drive(k, 1'b0, 1'b1, a, 1'b0, 6'd0, 32'h0);
    for (int t = 0; t < 20 && !granted; t++) begin
      @(negedge clk);
      if (gnt_w[k]) granted = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check($sformatf("dut%0d grant wait", k), 32'(granted), 32'd1);
  endtask

  task automatic rand_run(input int k, input int n);
    logic [31:0] a, base;
    base = base_of(k);
    for (int i = 0; i < n; i++) begin
      case ($urandom % 8)
        0:       a = base + ($urandom % 64) * 4 + 1 + ($urandom % 3);
        1:       a = base + (64 + ($urandom % 8)) * 4;
        2:       a = base - 4 * (1 + ($urandom % 4));
        default: a = base + ($urandom % 64) * 4;
      endcase
      drive(k, ($urandom % 64) == 0, ($urandom % 4) != 0, a,
            ($urandom % 16) == 0, 6'($urandom % 64), $urandom);
    end
  endtask

  initial begin
    rst_v = 2'b11; req_v = '0; addr_v = '0; ld_we_v = '0; ld_addr_v = '0; ld_wdata_v = '0;
    for (int k = 0; k < 2; k++) begin
      pend_valid[k] = 1'b0; cnt_m[k] = 32'd0; last_rdata[k] = 32'd0; last_err[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    rst_v = 2'b00;

    // Fill both arrays; words 0..3 of dut_a are fixed for the directed fetches.
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk);
      #1;
      ld_we_v       = 2'b11;
      ld_addr_v[0]  = 6'(i);
      ld_addr_v[1]  = 6'(i);
      ld_wdata_v[0] = (i == 0) ? 32'h0000_0093 : (i < 4) ? 32'(i) : $urandom;
      ld_wdata_v[1] = $urandom;
    end
    @(posedge clk);
    #1;
    ld_we_v = 2'b00;

    // Single fetch, then a back-to-back burst of three.
    fetch(0, 32'h0);
    idle(0, 4);
    fetch(0, 32'h0); fetch(0, 32'h4); fetch(0, 32'h8);
    idle(0, 4);
    // Misaligned and just-past-end fetches.
    fetch(0, 32'h2); fetch(0, 32'(DEPTH * 4));
    idle(0, 4);
    // Loader blocks the grant, then the new word is fetched.
    drive(0, 1'b0, 1'b1, 32'h10, 1'b1, 6'd4, 32'hCAFE_F00D);
    idle(0, 1);
    fetch(0, 32'h10);
    idle(0, 4);
    // Reset while in WAIT: the response is dropped, array survives.
    fetch(0, 32'h10);
    drive(0, 1'b1, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0);
    idle(0, 2);
    fetch(0, 32'h10);
    idle(0, 4);

    // Zero-wait instance: continuous fetches, one response per cycle.
    for (int i = 0; i < 8; i++) fetch(1, BASE_B + 32'(i * 4));
    fetch(1, BASE_B - 32'd4);
    idle(1, 4);

    fork
      rand_run(0, 400);
      rand_run(1, 400);
    join
    idle(0, 4);
    idle(1, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
